// File: rtl/memory_arbiter_if.sv
// Bus bundle for memory_arbiter: per-core instruction/data request ports plus the shared RAM port.
// The arbiter connects through the slave modport; the CPU/RAM side uses the master modport.
interface memory_arbiter_if #(
    parameter int CPUS = 2,
    parameter int AW   = 32,
    parameter int DW   = 32
);
    logic [CPUS-1:0]    iREN;
    logic [CPUS-1:0]    dREN;
    logic [CPUS-1:0]    dWEN;
    logic [CPUS*AW-1:0] iaddr;
    logic [CPUS*AW-1:0] daddr;
    logic [CPUS*DW-1:0] dstore;
    logic [CPUS-1:0]    iwait;
    logic [CPUS-1:0]    dwait;
    logic [CPUS*DW-1:0] iload;
    logic [CPUS*DW-1:0] dload;
    logic [AW-1:0]      ramaddr;
    logic [DW-1:0]      ramstore;
    logic               ramREN;
    logic               ramWEN;
    logic [DW-1:0]      ramload;
    logic [1:0]         ramstate;
    logic               arb_err;

    modport slave (
        input  iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
        output iwait, dwait, iload, dload, ramaddr, ramstore, ramREN, ramWEN, arb_err
    );

    modport master (
        output iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
        input  iwait, dwait, iload, dload, ramaddr, ramstore, ramREN, ramWEN, arb_err
    );
endinterface

// File: rtl/memory_arbiter.sv
// Round-robin arbiter serialising per-core I/D requests onto one RAM port (IDLE/XFER FSM).
// Optional transfer watchdog enabled by defining ARB_TIMEOUT_EN.
module memory_arbiter #(
    parameter int CPUS    = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic             CLK,
    input  logic             RST,
    memory_arbiter_if.slave  bus
);
    localparam int PW = (CPUS > 1) ? $clog2(CPUS) : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_XFER = 1'b1;

    localparam logic [1:0] T_I  = 2'd0;
    localparam logic [1:0] T_DR = 2'd1;
    localparam logic [1:0] T_DW = 2'd2;

    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    logic [0:0]      state_q, state_d;
    logic [PW-1:0]   last_q, last_d;
    logic [PW-1:0]   gnt_cpu_q, gnt_cpu_d;
    logic [1:0]      gnt_type_q, gnt_type_d;
    logic [AW-1:0]   ramaddr_q, ramaddr_d;
    logic [DW-1:0]   ramstore_q, ramstore_d;
    logic            ramREN_q, ramREN_d;
    logic            ramWEN_q, ramWEN_d;
    logic [CPUS-1:0] pri_i_q, pri_i_d;

    logic [CPUS-1:0]    req_d_s;
    logic               found_s;
    logic [PW-1:0]      sel_cpu_s;
    logic [1:0]         sel_type_s;
    logic               held_s;
    logic               complete_s;
    logic               timeout_s;
    logic [CPUS-1:0]    iwait_s;
    logic [CPUS-1:0]    dwait_s;
    logic [CPUS*DW-1:0] iload_s;
    logic [CPUS*DW-1:0] dload_s;

    function automatic int rr_idx(input logic [PW-1:0] last, input int k);
        return (int'(last) + k) % CPUS;
    endfunction

    assign req_d_s = bus.dREN | bus.dWEN;

    // Pick the first requesting core after the last served one; pri_i_q lets a core's
    // instruction request go ahead of its data request once data was just served.
    always_comb begin
        found_s    = 1'b0;
        sel_cpu_s  = {PW{1'b0}};
        sel_type_s = T_I;
        for (int k = 1; k <= CPUS; k++) begin
            if (!found_s && (req_d_s[rr_idx(last_q, k)] || bus.iREN[rr_idx(last_q, k)])) begin
                found_s   = 1'b1;
                sel_cpu_s = PW'(rr_idx(last_q, k));
                if (req_d_s[rr_idx(last_q, k)] &&
                    !(pri_i_q[rr_idx(last_q, k)] && bus.iREN[rr_idx(last_q, k)])) begin
                    sel_type_s = bus.dWEN[rr_idx(last_q, k)] ? T_DW : T_DR;
                end else begin
                    sel_type_s = T_I;
                end
            end else begin
                found_s = found_s;
            end
        end
    end

    // Is the granted request still being asserted by its core.
    always_comb begin
        case (gnt_type_q)
            T_I:     held_s = bus.iREN[gnt_cpu_q];
            T_DR:    held_s = bus.dREN[gnt_cpu_q];
            T_DW:    held_s = bus.dWEN[gnt_cpu_q];
            default: held_s = 1'b0;
        endcase
    end

    assign complete_s = (state_q == S_XFER) && held_s && (bus.ramstate == RS_ACCESS);

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;

    // Transfer cycle counter, held at zero while idle so each XFER starts from zero.
    always_comb begin
        if (state_q == S_XFER) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = {CW{1'b0}};
        end
    end

    // Watchdog counter register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_s = (state_q == S_XFER) && held_s && (bus.ramstate != RS_ACCESS) &&
                       (bus.ramstate != RS_ERROR) && (cnt_q == CW'(TIMEOUT - 1));
`else
    assign timeout_s = 1'b0;
`endif

    // FSM next state; withdrawal beats completion, which beats RAM error and timeout.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        gnt_cpu_d  = gnt_cpu_q;
        gnt_type_d = gnt_type_q;
        ramaddr_d  = ramaddr_q;
        ramstore_d = ramstore_q;
        pri_i_d    = pri_i_q;
        case (state_q)
            S_IDLE: begin
                if (found_s) begin
                    state_d    = S_XFER;
                    gnt_cpu_d  = sel_cpu_s;
                    gnt_type_d = sel_type_s;
                    if (sel_type_s == T_I) begin
                        ramaddr_d = bus.iaddr[int'(sel_cpu_s)*AW +: AW];
                    end else begin
                        ramaddr_d = bus.daddr[int'(sel_cpu_s)*AW +: AW];
                    end
                    if (sel_type_s == T_DW) begin
                        ramstore_d = bus.dstore[int'(sel_cpu_s)*DW +: DW];
                    end else begin
                        ramstore_d = ramstore_q;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_XFER: begin
                if (!held_s) begin
                    state_d = S_IDLE;
                end else if (complete_s) begin
                    state_d = S_IDLE;
                    last_d  = gnt_cpu_q;
                    if (gnt_type_q == T_I) begin
                        pri_i_d[gnt_cpu_q] = 1'b0;
                    end else begin
                        pri_i_d[gnt_cpu_q] = bus.iREN[gnt_cpu_q];
                    end
                end else if (bus.ramstate == RS_ERROR) begin
                    state_d = S_IDLE;
                end else if (timeout_s) begin
                    state_d = S_IDLE;
                    last_d  = gnt_cpu_q;
                end else begin
                    state_d = S_XFER;
                end
            end
            default: state_d = S_IDLE;
        endcase
        ramREN_d = (state_d == S_XFER) && (gnt_type_d != T_DW);
        ramWEN_d = (state_d == S_XFER) && (gnt_type_d == T_DW);
    end

    // Only the completing channel sees its wait bit drop and its load carry RAM data.
    always_comb begin
        iwait_s = {CPUS{1'b1}};
        dwait_s = {CPUS{1'b1}};
        iload_s = {(CPUS*DW){1'b0}};
        dload_s = {(CPUS*DW){1'b0}};
        if (complete_s) begin
            if (gnt_type_q == T_I) begin
                iwait_s[gnt_cpu_q]                 = 1'b0;
                iload_s[int'(gnt_cpu_q)*DW +: DW] = bus.ramload;
            end else begin
                dwait_s[gnt_cpu_q] = 1'b0;
                if (gnt_type_q == T_DR) begin
                    dload_s[int'(gnt_cpu_q)*DW +: DW] = bus.ramload;
                end else begin
                    dload_s = {(CPUS*DW){1'b0}};
                end
            end
        end else begin
            iwait_s = {CPUS{1'b1}};
        end
    end

    // State and registered RAM-side outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            last_q     <= PW'(CPUS - 1);
            gnt_cpu_q  <= {PW{1'b0}};
            gnt_type_q <= T_I;
            ramaddr_q  <= {AW{1'b0}};
            ramstore_q <= {DW{1'b0}};
            ramREN_q   <= 1'b0;
            ramWEN_q   <= 1'b0;
            pri_i_q    <= {CPUS{1'b0}};
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            gnt_cpu_q  <= gnt_cpu_d;
            gnt_type_q <= gnt_type_d;
            ramaddr_q  <= ramaddr_d;
            ramstore_q <= ramstore_d;
            ramREN_q   <= ramREN_d;
            ramWEN_q   <= ramWEN_d;
            pri_i_q    <= pri_i_d;
        end
    end

    assign bus.iwait    = iwait_s;
    assign bus.dwait    = dwait_s;
    assign bus.iload    = iload_s;
    assign bus.dload    = dload_s;
    assign bus.ramaddr  = ramaddr_q;
    assign bus.ramstore = ramstore_q;
    assign bus.ramREN   = ramREN_q;
    assign bus.ramWEN   = ramWEN_q;
    assign bus.arb_err  = timeout_s;
endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter (CPUS=2, TIMEOUT=8) with an expected-grant scoreboard.
module tb_memory_arbiter;
    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;
    localparam int K_I = 0, K_DR = 1, K_DW = 2;

    typedef struct {
        int          cpu;
        int          kind;
        logic [31:0] addr;
        logic [31:0] store;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    exp_t e;

    memory_arbiter_if #(.CPUS(2), .AW(32), .DW(32)) bus ();

    memory_arbiter #(.CPUS(2), .AW(32), .DW(32), .TIMEOUT(8)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push(input int cpu, input int kind, input logic [31:0] addr, input logic [31:0] store);
        exp_t x;
        x.cpu = cpu; x.kind = kind; x.addr = addr; x.store = store;
        exp_q.push_back(x);
    endtask

    task automatic wait_grant(output exp_t eg);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            bus.ramstate = FREE;
            #1;
            n++;
        end while (!(bus.ramREN || bus.ramWEN) && n < 20);
        chk("grant_seen", 64'(bus.ramREN | bus.ramWEN), 64'd1);
        chk("grant_latency", 64'(n), 64'd1);
        chk("sb_nonempty", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) eg = exp_q.pop_front();
        else begin eg.cpu = 0; eg.kind = K_I; eg.addr = 32'h0; eg.store = 32'h0; end
        chk("ramaddr", 64'(bus.ramaddr), 64'(eg.addr));
        chk("ramREN", 64'(bus.ramREN), 64'(eg.kind != K_DW));
        chk("ramWEN", 64'(bus.ramWEN), 64'(eg.kind == K_DW));
        if (eg.kind == K_DW) chk("ramstore", 64'(bus.ramstore), 64'(eg.store));
        chk("xfer_iwait", 64'(bus.iwait), 64'h3);
        chk("xfer_dwait", 64'(bus.dwait), 64'h3);
    endtask

    // drop: 0 keep requests, 1 withdraw the served request, 2 withdraw everything
    task automatic finish(input exp_t ef, input int nbusy, input logic [31:0] ld, input int drop);
        logic [1:0]  iw, dw;
        logic [63:0] il, dl;
        for (int i = 0; i < nbusy; i++) begin
            @(negedge clk);
            bus.ramstate = BUSY;
            #1;
            chk("busy_iwait", 64'(bus.iwait), 64'h3);
            chk("busy_dwait", 64'(bus.dwait), 64'h3);
        end
        @(negedge clk);
        bus.ramstate = ACCESS;
        bus.ramload  = ld;
        #1;
        iw = 2'b11; dw = 2'b11; il = 64'h0; dl = 64'h0;
        if (ef.kind == K_I) begin
            iw[ef.cpu] = 1'b0;
            il[ef.cpu*32 +: 32] = ld;
        end else begin
            dw[ef.cpu] = 1'b0;
            if (ef.kind == K_DR) dl[ef.cpu*32 +: 32] = ld;
        end
        chk("done_iwait", 64'(bus.iwait), 64'(iw));
        chk("done_dwait", 64'(bus.dwait), 64'(dw));
        chk("done_iload", bus.iload, il);
        chk("done_dload", bus.dload, dl);
        @(negedge clk);
        bus.ramstate = FREE;
        bus.ramload  = 32'h0;
        if (drop == 2) begin
            bus.iREN = 2'b00; bus.dREN = 2'b00; bus.dWEN = 2'b00;
        end else if (drop == 1) begin
            if (ef.kind == K_I) bus.iREN[ef.cpu] = 1'b0;
            else if (ef.kind == K_DR) bus.dREN[ef.cpu] = 1'b0;
            else bus.dWEN[ef.cpu] = 1'b0;
        end
        #1;
        chk("after_iwait", 64'(bus.iwait), 64'h3);
        chk("after_strobe", 64'({bus.ramREN, bus.ramWEN}), 64'h0);
    endtask

    task automatic serve(input int nbusy, input logic [31:0] ld, input int drop);
        exp_t es;
        wait_grant(es);
        finish(es, nbusy, ld, drop);
    endtask

    initial begin
        bus.iREN = 2'b00; bus.dREN = 2'b00; bus.dWEN = 2'b00;
        bus.iaddr = 64'h0; bus.daddr = 64'h0; bus.dstore = 64'h0;
        bus.ramload = 32'h0; bus.ramstate = FREE;

        // T1: reset values
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ramREN", 64'(bus.ramREN), 64'h0);
        chk("rst_ramWEN", 64'(bus.ramWEN), 64'h0);
        chk("rst_iwait", 64'(bus.iwait), 64'h3);
        chk("rst_dwait", 64'(bus.dwait), 64'h3);
        chk("rst_ramaddr", 64'(bus.ramaddr), 64'h0);
        chk("rst_ramstore", 64'(bus.ramstore), 64'h0);
        chk("rst_loads", bus.iload | bus.dload, 64'h0);
        chk("rst_arb_err", 64'(bus.arb_err), 64'h0);

        // T3: c0 I+DW, c1 DR, all held -> c0-DW, c1-DR, c0-I
        @(negedge clk);
        rst = 1'b0;
        bus.iREN = 2'b01; bus.iaddr[31:0] = 32'h20;
        bus.dWEN = 2'b01; bus.daddr[31:0] = 32'h80; bus.dstore[31:0] = 32'h1234;
        bus.dREN = 2'b10; bus.daddr[63:32] = 32'h90;
        push(0, K_DW, 32'h80, 32'h1234);
        push(1, K_DR, 32'h90, 32'h0);
        push(0, K_I, 32'h20, 32'h0);
        serve(2, 32'h0, 0);
        serve(1, 32'hCAFE_0001, 0);
        serve(0, 32'h0BAD_F00D, 2);

        // T2: single instruction fetch, two BUSY then ACCESS
        @(negedge clk);
        bus.iREN[0] = 1'b1; bus.iaddr[31:0] = 32'h40;
        push(0, K_I, 32'h40, 32'h0);
        serve(2, 32'hDEAD, 1);

        // T4: c1 withdraws mid-transfer; last stays on core 0 so c1 wins next
        @(negedge clk);
        bus.dREN[1] = 1'b1; bus.daddr[63:32] = 32'h90;
        push(1, K_DR, 32'h90, 32'h0);
        wait_grant(e);
        @(negedge clk);
        bus.ramstate = BUSY;
        #1;
        chk("t4_busy_dwait", 64'(bus.dwait), 64'h3);
        @(negedge clk);
        bus.dREN[1] = 1'b0;
        #1;
        chk("t4_nodrop_dwait", 64'(bus.dwait), 64'h3);
        chk("t4_nodrop_dload", bus.dload, 64'h0);
        @(negedge clk);
        bus.ramstate = FREE;
        #1;
        chk("t4_abort_ramREN", 64'(bus.ramREN), 64'h0);
        bus.iREN[0] = 1'b1; bus.iaddr[31:0] = 32'h44;
        bus.dREN[1] = 1'b1; bus.daddr[63:32] = 32'h94;
        push(1, K_DR, 32'h94, 32'h0);
        push(0, K_I, 32'h44, 32'h0);
        serve(1, 32'h1111_2222, 1);
        serve(0, 32'h3333_4444, 1);

        // T5: RAM ERROR drops the transfer, the write is re-granted and completes
        @(negedge clk);
        bus.dWEN[1] = 1'b1; bus.daddr[63:32] = 32'hA0; bus.dstore[63:32] = 32'h5555;
        push(1, K_DW, 32'hA0, 32'h5555);
        push(1, K_DW, 32'hA0, 32'h5555);
        wait_grant(e);
        @(negedge clk);
        bus.ramstate = ERROR;
        #1;
        chk("t5_err_dwait", 64'(bus.dwait), 64'h3);
        @(negedge clk);
        bus.ramstate = FREE;
        #1;
        chk("t5_err_ramWEN", 64'(bus.ramWEN), 64'h0);
        serve(0, 32'h0, 1);

        // T6: RAM stuck BUSY with both cores fetching
        @(negedge clk);
        bus.iREN = 2'b11; bus.iaddr = {32'hB4, 32'hB0};
        push(0, K_I, 32'hB0, 32'h0);
        wait_grant(e);
`ifdef ARB_TIMEOUT_EN
        for (int k = 2; k <= 8; k++) begin
            @(negedge clk);
            bus.ramstate = BUSY;
            #1;
            chk("t6_arb_err", 64'(bus.arb_err), 64'(k == 8));
        end
        @(negedge clk);
        bus.ramstate = FREE;
        #1;
        chk("t6_timeout_ramREN", 64'(bus.ramREN), 64'h0);
        chk("t6_err_cleared", 64'(bus.arb_err), 64'h0);
        push(1, K_I, 32'hB4, 32'h0);
        serve(0, 32'h77, 1);
        push(0, K_I, 32'hB0, 32'h0);
        serve(0, 32'h66, 1);
`else
        for (int k = 2; k <= 12; k++) begin
            @(negedge clk);
            bus.ramstate = BUSY;
            #1;
            chk("t6_still_xfer", 64'(bus.ramREN), 64'h1);
            chk("t6_no_err", 64'(bus.arb_err), 64'h0);
        end
        finish(e, 0, 32'h66, 1);
        push(1, K_I, 32'hB4, 32'h0);
        serve(0, 32'h77, 1);
`endif
        chk("sb_drained", 64'(exp_q.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
